// File: rtl/debug_module_cpu_oci_dct_pkg.sv
// Shared widths, FSM state type and trace frame codes for the OCI data-trace packer.
package debug_module_cpu_oci_dct_pkg;

    localparam int unsigned FRAME_W    = 2;
    localparam int unsigned NUM_FRAMES = 15;
    localparam int unsigned BUF_W      = FRAME_W * NUM_FRAMES;
    localparam int unsigned CNT_W      = 4;
    localparam int unsigned DROP_W     = 8;
    localparam int unsigned PKT_W      = CNT_W + BUF_W;

    typedef enum logic {
        ST_ACCUM,
        ST_FULL
    } dct_state_e;

    localparam logic [FRAME_W-1:0] FRAME_NONE   = 2'b00;
    localparam logic [FRAME_W-1:0] FRAME_LOAD   = 2'b01;
    localparam logic [FRAME_W-1:0] FRAME_STORE  = 2'b10;
    localparam logic [FRAME_W-1:0] FRAME_MARKER = 2'b11;

endpackage

// File: rtl/debug_module_cpu_oci_dct_outreg.sv
// One-entry valid/ready holding register for finished trace packets.
module debug_module_cpu_oci_dct_outreg
    import debug_module_cpu_oci_dct_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [PKT_W-1:0] load_data,
    input  logic             pkt_ready,
    output logic             pkt_valid,
    output logic [PKT_W-1:0] pkt_data,
    output logic             out_free
);

    logic             valid_q, valid_d;
    logic [PKT_W-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        // load is only issued while out_free, so it may overlap a handshake
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
        end else if (pkt_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign pkt_valid = valid_q;
    assign pkt_data  = data_q;
    assign out_free  = !valid_q || pkt_ready;

endmodule

// File: rtl/debug_module_cpu_oci_dct_packer.sv
// Packs 2-bit compressed data-trace frames into 15-frame packets for the trace FIFO,
// with flush support and a saturating count of frames dropped under backpressure.
module debug_module_cpu_oci_dct_packer
    import debug_module_cpu_oci_dct_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               trace_enable,
    input  logic               frame_valid,
    input  logic [FRAME_W-1:0] frame_data,
    input  logic               flush,
    output logic [BUF_W-1:0]   dct_buffer,
    output logic [CNT_W-1:0]   dct_count,
    output logic               pkt_valid,
    input  logic               pkt_ready,
    output logic [PKT_W-1:0]   pkt_data,
    output logic               overflow,
    input  logic               overflow_clr,
    output logic [DROP_W-1:0]  drop_cnt
);

    dct_state_e        state_q, state_d;
    logic [BUF_W-1:0]  buf_q, buf_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              pend_q, pend_d;
    logic              ovf_q, ovf_d;
    logic [DROP_W-1:0] drop_q, drop_d;

    logic              out_free;
    logic              load;
    logic [PKT_W-1:0]  load_data;
    logic              frame_in;
    logic              flush_eff;
    logic              drop;
    logic [BUF_W-1:0]  buf_n;
    logic [CNT_W-1:0]  cnt_n;

    always_comb begin
        frame_in  = frame_valid && trace_enable;
        flush_eff = flush || pend_q;
        state_d   = state_q;
        buf_d     = buf_q;
        cnt_d     = cnt_q;
        pend_d    = flush_eff;
        load      = 1'b0;
        load_data = '0;
        drop      = 1'b0;
        buf_n     = buf_q;
        cnt_n     = cnt_q;

        unique case (state_q)
            ST_FULL: begin
                if (out_free) begin
                    // held packet leaves; a same-cycle frame seeds the next buffer
                    load      = 1'b1;
                    load_data = {cnt_q, buf_q};
                    state_d   = ST_ACCUM;
                    buf_d     = frame_in ? BUF_W'(frame_data) : '0;
                    cnt_d     = frame_in ? CNT_W'(1) : '0;
                    pend_d    = flush_eff && frame_in;
                end else begin
                    drop = frame_in;
                end
            end
            default: begin
                if (frame_in) begin
                    buf_n = {buf_q[BUF_W-FRAME_W-1:0], frame_data};
                    cnt_n = cnt_q + CNT_W'(1);
                end
                buf_d = buf_n;
                cnt_d = cnt_n;
                if (cnt_n == CNT_W'(NUM_FRAMES)) begin
                    if (out_free) begin
                        load      = 1'b1;
                        load_data = {cnt_n, buf_n};
                        buf_d     = '0;
                        cnt_d     = '0;
                        pend_d    = 1'b0;
                    end else begin
                        state_d = ST_FULL;
                    end
                end else if (flush_eff) begin
                    if (cnt_n == '0) begin
                        pend_d = 1'b0;
                    end else if (out_free) begin
                        load      = 1'b1;
                        load_data = {cnt_n, buf_n};
                        buf_d     = '0;
                        cnt_d     = '0;
                        pend_d    = 1'b0;
                    end
                end
            end
        endcase

        ovf_d  = ovf_q;
        drop_d = drop_q;
        if (overflow_clr) begin
            ovf_d  = 1'b0;
            drop_d = '0;
        end else if (drop) begin
            ovf_d = 1'b1;
            if (drop_q != '1) begin
                drop_d = drop_q + DROP_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_ACCUM;
            buf_q   <= '0;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            ovf_q   <= 1'b0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            drop_q  <= drop_d;
        end
    end

    debug_module_cpu_oci_dct_outreg u_outreg (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (load),
        .load_data (load_data),
        .pkt_ready (pkt_ready),
        .pkt_valid (pkt_valid),
        .pkt_data  (pkt_data),
        .out_free  (out_free)
    );

    assign dct_buffer = buf_q;
    assign dct_count  = cnt_q;
    assign overflow   = ovf_q;
    assign drop_cnt   = drop_q;

endmodule

// File: doc/debug_module_cpu_oci_dct_packer.md
Name: debug_module_cpu_oci_dct_packer

Overview:
- Upstream feeder of the OCI trace test-bench stage.
- Accepts 2-bit compressed data-trace frames from the OCI dtrace logic and packs up to 15 frames into a 30-bit accumulation buffer.
- Exposes the live buffer and count as dct_buffer and dct_count.
- Hands completed or flushed packets to the trace FIFO over a valid/ready interface, and counts frames dropped under backpressure.

Parameters:
- FRAME_W, 2, bits per trace frame.
- NUM_FRAMES, 15, frames per packet; BUF_W = FRAME_W*NUM_FRAMES = 30.
- CNT_W, 4, width of the frame count.
- DROP_W, 8, width of the saturating drop counter.

Ports:
- clk  in  1  single clock.
- reset_n  in  1  asynchronous, active-low reset.
- trace_enable  in  1  when low, frames are ignored (neither accepted nor counted as dropped).
- frame_valid  in  1  frame_data is valid this cycle; no ready is returned, because the source cannot stall.
- frame_data  in  2  compressed trace frame.
- flush  in  1  single-cycle pulse: emit the partial buffer.
- dct_buffer  out  30  live accumulation buffer; newest frame in [1:0].
- dct_count  out  4  number of valid frames in dct_buffer (0..15).
- pkt_valid  out  1  output packet valid.
- pkt_ready  in  1  downstream accepts the packet.
- pkt_data  out  34  {count[3:0], buffer[29:0]}.
- overflow  out  1  sticky: a frame was dropped.
- overflow_clr  in  1  clears overflow and drop_cnt.
- drop_cnt  out  8  number of dropped frames, saturating at 255.

Behaviour:
- Reset (asynchronous, on reset_n low): all outputs are 0; buffer, count, flush_pend, output register, overflow and drop_cnt are all cleared. Reset asserted mid-packet discards everything.
- Accept condition: accept = frame_valid & trace_enable & !drop.
- Accepting a frame: buffer <= {buffer[27:0], frame_data}; count += 1. Valid frames occupy buffer[2*count-1:0]; bits above that are 0.
- Output-free signal: out_free = !pkt_valid | pkt_ready.
- Full case: when the buffer would reach 15 frames this cycle:
  - if out_free: pkt_data <= {4'd15, buf_next}; buffer and count clear in the same edge. pkt_valid rises on the next cycle, so latency is 1 cycle from the 15th frame.
  - if !out_free: the buffer holds with count=15 ("FULL" state).
- FULL state with a frame arriving:
  - if out_free: the held buffer transfers, and the new frame starts a fresh buffer (count=1).
  - if !out_free: the frame is dropped; overflow <= 1 and drop_cnt increments (saturating).
- FULL state, no frame: transfer as soon as out_free.
- flush: sets flush_pend. While flush_pend is set and count_next > 0 and out_free:
  - emit {count_next, buf_next}, including any frame arriving in the same cycle;
  - clear buffer, count and flush_pend.
- flush with count_next == 0: flush_pend clears and no packet is produced.
- flush and the 15th frame in the same cycle: only one packet is produced (count 15).
- Output register:
  - pkt_data is stable while pkt_valid & !pkt_ready.
  - pkt_valid drops on the cycle after a handshake unless a new transfer loads in the same edge (back-to-back packets are allowed).
- overflow_clr: has priority over a same-cycle drop. Both counters read 0 afterwards, and that cycle's drop is not counted.
- trace_enable low: the buffer holds. Flush still works on the held contents.
- State machine (2 states):
  - ACCUM → FULL when count reaches 15 and !out_free.
  - FULL → ACCUM when out_free.

Decomposition:
- Package debug_module_cpu_oci_dct_pkg holds:
  - FRAME_W, NUM_FRAMES, BUF_W, CNT_W, PKT_W=34;
  - a state enum {ST_ACCUM, ST_FULL};
  - frame code constants (2'b00 none, 2'b01 load, 2'b10 store, 2'b11 marker).
- One sub-module, debug_module_cpu_oci_dct_outreg: the one-entry valid/ready holding register, with a load strobe, pkt_valid/pkt_ready and data hold.

Test Plan:
- Fill: 15 frames of 2'b01 with pkt_ready=1 → one cycle later pkt_valid=1, pkt_data={4'hF, 30'h15555555}; dct_count=0.
- Flush partial: frames 11, 10, 01, then flush → pkt_data={4'd3, 30'h39}; flush with count 0 → no pkt_valid.
- Backpressure: pkt_ready=0 and two full packets' worth of frames → second buffer holds count=15; the next 3 frames are dropped, drop_cnt=3, overflow=1. Raising pkt_ready gives two packets back-to-back, the second being the held buffer.
- Simultaneous events: FULL + out_free + frame in the same cycle → the held packet emits, and dct_count=1 with dct_buffer[1:0]=frame. overflow_clr coincident with a drop → drop_cnt=0, overflow=0.
- Saturation: 300 drops → drop_cnt=255.
- Reset mid-packet: reset_n low after 7 frames with pkt_valid=1 → all outputs 0 asynchronously; after release, the first packet contains only post-reset frames.
